// File: rtl/wdt_multi_wrapper.sv
// Multi-channel watchdog timer bank behind an AXI4 slave port.
// Each channel has an enable, a kick, a timeout compare value, a free-running count and a sticky timeout flag.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module wdt_multi_wrapper #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [`AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [`AXI_IDS_BITS-1:0]   ARID,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
  input  logic [1:0]                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [`AXI_IDS_BITS-1:0]   RID,
  output logic [`AXI_DATA_BITS-1:0]  RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_CH-1:0]          WTO,
  output logic                       IRQ
);

  // state | meaning
  // IDLE  | waiting for AW or AR (AW has priority)
  // WRITE | accepting W beats, one register commit per beat
  // WRESP | presenting the B response
  // READ  | presenting R beats from the registered read data
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  localparam int DW = `AXI_DATA_BITS;
  localparam int LW = `AXI_LEN_BITS;
  localparam int IW = `AXI_IDS_BITS;

  state_t state, state_nx;

  logic [IW-1:0]     awid_q, arid_q;
  logic [11:0]       addr_q;
  logic [LW-1:0]     arlen_q, beat_q;
  logic              err_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  logic [NUM_CH-1:0] en_q, wto_q;
  logic [CNT_W-1:0]  tocnt_q [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];

  logic              wr_fire, wr_err, rd_err;
  logic [11:0]       rd_addr;
  logic [DW-1:0]     rd_val, wmask;
  logic [NUM_CH-1:0] en_wr, kick, toc_wr, w1c, hit;

  logic unused_sigs;
  assign unused_sigs = ^{AWLEN, AWSIZE, AWBURST, ARSIZE, ARBURST,
                         AWADDR[`AXI_ADDR_BITS-1:12], ARADDR[`AXI_ADDR_BITS-1:12]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    AWREADY  = 1'b0;
    ARREADY  = 1'b0;
    WREADY   = 1'b0;
    BVALID   = 1'b0;
    RVALID   = 1'b0;
    case (state)
      IDLE: begin
        AWREADY = 1'b1;
        ARREADY = !AWVALID;
        if (AWVALID)      state_nx = WRITE;
        else if (ARVALID) state_nx = READ;
      end
      WRITE: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) state_nx = WRESP;
      end
      WRESP: begin
        BVALID = 1'b1;
        if (BREADY) state_nx = IDLE;
      end
      READ: begin
        RVALID = 1'b1;
        if (RREADY && rlast_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign BID   = awid_q;
  assign BRESP = {err_q, 1'b0};
  assign RID   = arid_q;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign RLAST = rlast_q & RVALID;
  assign WTO   = wto_q;
  assign IRQ   = |wto_q;

  // Read data is decoded one beat ahead and registered so it stays put during R stalls.
  assign rd_addr = (state == IDLE) ? ARADDR[11:0] : addr_q + 12'd4;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr[1:0] == 2'b00 && rd_addr[11:4] == 8'(c)) begin
        rd_err = 1'b0;
        case (rd_addr[3:2])
          2'd0: rd_val = DW'(en_q[c]);
          2'd1: rd_val = '0;
          2'd2: rd_val = DW'(tocnt_q[c]);
          2'd3: rd_val = DW'(count_q[c]);
        endcase
      end
    end
    if (rd_addr == 12'h100) begin
      rd_err = 1'b0;
      rd_val = DW'(wto_q);
    end
  end

  assign wr_fire = (state == WRITE) && WVALID;

  always_comb begin
    en_wr  = '0;
    kick   = '0;
    toc_wr = '0;
    w1c    = '0;
    wr_err = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr_q[1:0] == 2'b00 && addr_q[11:4] == 8'(c)) begin
        wr_err = 1'b0;
        case (addr_q[3:2])
          2'd0:    en_wr[c]  = wr_fire & WSTRB[0];
          2'd1:    kick[c]   = wr_fire & WSTRB[0] & WDATA[0];
          2'd2:    toc_wr[c] = wr_fire;
          default: ;
        endcase
      end
    end
    if (addr_q == 12'h100) begin
      wr_err = 1'b0;
      if (wr_fire && WSTRB[0]) w1c = WDATA[NUM_CH-1:0];
    end
  end

  always_comb begin
    for (int b = 0; b < DW/8; b++) wmask[b*8 +: 8] = {8{WSTRB[b]}};
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) hit[c] = (count_q[c] == tocnt_q[c]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awid_q  <= '0;
      arid_q  <= '0;
      addr_q  <= '0;
      arlen_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AWVALID) begin
            awid_q <= AWID;
            addr_q <= AWADDR[11:0];
            err_q  <= 1'b0;
          end else if (ARVALID) begin
            arid_q  <= ARID;
            addr_q  <= ARADDR[11:0];
            arlen_q <= ARLEN;
            beat_q  <= '0;
            rdata_q <= rd_val;
            rresp_q <= rd_err ? 2'b10 : 2'b00;
            rlast_q <= (ARLEN == '0);
          end
        end
        WRITE: begin
          if (WVALID) begin
            addr_q <= addr_q + 12'd4;
            if (wr_err) err_q <= 1'b1;
          end
        end
        READ: begin
          if (RREADY) begin
            addr_q  <= addr_q + 12'd4;
            beat_q  <= beat_q + 1'b1;
            rdata_q <= rd_val;
            rresp_q <= rd_err ? 2'b10 : 2'b00;
            rlast_q <= (LW'(beat_q + 1'b1) == arlen_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Kick beats a same-edge timeout; a new timeout beats a same-edge W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      wto_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tocnt_q[c] <= '0;
        count_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_wr[c]) en_q[c] <= WDATA[0];
        if (toc_wr[c])
          tocnt_q[c] <= (tocnt_q[c] & ~wmask[CNT_W-1:0]) | (WDATA[CNT_W-1:0] & wmask[CNT_W-1:0]);
        if (!en_q[c] || kick[c])
          count_q[c] <= '0;
        else if (!wto_q[c] && !hit[c] && count_q[c] != '1)
          count_q[c] <= count_q[c] + 1'b1;
        wto_q[c] <= (en_q[c] & ~wto_q[c] & hit[c] & ~kick[c]) | (wto_q[c] & ~w1c[c]);
      end
    end
  end

endmodule

// File: tb/tb_wdt_multi_wrapper.sv
// Directed bench for wdt_multi_wrapper: register access, timeout timing, kicks, W1C and reset abort.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_wdt_multi_wrapper;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [`AXI_IDS_BITS-1:0]  AWID, BID, ARID, RID;
  logic [`AXI_ADDR_BITS-1:0] AWADDR, ARADDR;
  logic [`AXI_LEN_BITS-1:0]  AWLEN, ARLEN;
  logic [`AXI_SIZE_BITS-1:0] AWSIZE, ARSIZE;
  logic [1:0]                AWBURST, ARBURST, BRESP, RRESP;
  logic                      AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic                      ARVALID, ARREADY, RLAST, RVALID, RREADY, IRQ;
  logic [`AXI_DATA_BITS-1:0] WDATA, RDATA;
  logic [`AXI_STRB_BITS-1:0] WSTRB;
  logic [3:0]                WTO;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_commit = 0;

  logic [31:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];

  wdt_multi_wrapper #(.NUM_CH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .WTO(WTO), .IRQ(IRQ)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All drives and samples happen 1 time unit after a rising edge.
  task automatic axi_write(input logic [11:0] addr, input int n, input logic [127:0] dv,
                           input logic [3:0] strb, output logic [1:0] resp);
    int t;
    AWVALID = 1'b1; AWADDR = {20'h0, addr}; AWLEN = 8'(n - 1); AWID = 8'h5A;
    #1;
    t = 0;
    while (!AWREADY && t < 20) begin @(posedge clk); #1; t++; end
    check("aw_ready", AWREADY, 1'b1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int b = 0; b < n; b++) begin
      WVALID = 1'b1; WDATA = dv[b*32 +: 32]; WSTRB = strb; WLAST = (b == n - 1);
      t = 0;
      while (!WREADY && t < 20) begin @(posedge clk); #1; t++; end
      check("w_ready", WREADY, 1'b1);
      @(posedge clk); #1;
      last_commit = cyc;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 20) begin @(posedge clk); #1; t++; end
    check("b_valid", BVALID, 1'b1);
    check("b_id", BID, 8'h5A);
    resp = BRESP;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int n, input int stall);
    int t;
    logic [31:0] first;
    ARVALID = 1'b1; ARADDR = {20'h0, addr}; ARLEN = 8'(n - 1); ARID = 8'hC3;
    #1;
    t = 0;
    while (!ARREADY && t < 20) begin @(posedge clk); #1; t++; end
    check("ar_ready", ARREADY, 1'b1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int b = 0; b < n; b++) begin
      t = 0;
      while (!RVALID && t < 20) begin @(posedge clk); #1; t++; end
      check("r_valid", RVALID, 1'b1);
      first = RDATA;
      if (b % 2 == 0) begin
        for (int s = 0; s < stall; s++) begin
          RREADY = 1'b0;
          @(posedge clk); #1;
          check("r_hold", RDATA, first);
          check("r_hold_last", RLAST, (b == n - 1));
        end
      end
      RREADY = 1'b1;
      rd_data[b] = RDATA; rd_resp[b] = RRESP; rd_last[b] = RLAST;
      check("r_id", RID, 8'hC3);
      @(posedge clk); #1;
      RREADY = 1'b0;
    end
  endtask

  task automatic wr1(input logic [11:0] addr, input logic [31:0] d, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, 1, {96'h0, d}, 4'hF, r);
    check("bresp", r, exp_resp);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    axi_read(addr, 1, 0);
    check(tag, rd_data[0], exp);
    check("rd_single_last", rd_last[0], 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e, rise, t, st;
    logic [1:0] r;
    rst = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wto", WTO, 4'h0);
    check("rst_irq", IRQ, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_awready", AWREADY, 1'b1);
    check("rst_arready", ARREADY, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // ch0 timeout exactly TOCNT+1 edges after the enabling beat
    wr1(12'h008, 32'd5, 2'b00);
    wr1(12'h000, 32'd1, 2'b00);
    e = last_commit;
    check("wto0_early", WTO[0], 1'b0);
    t = 0;
    while (!WTO[0] && t < 30) begin @(posedge clk); #1; t++; end
    rise = cyc;
    check("wto0_delay", rise - e, 6);
    check("irq_set", IRQ, 1'b1);

    // 3-beat read with stalls: TOCNT0, COUNT0 (held at 5), EN1
    axi_read(12'h008, 3, 2);
    check("rd3_b0", rd_data[0], 32'd5);
    check("rd3_b1", rd_data[1], 32'd5);
    check("rd3_b2", rd_data[2], 32'd0);
    check("rd3_last0", rd_last[0], 1'b0);
    check("rd3_last1", rd_last[1], 1'b0);
    check("rd3_last2", rd_last[2], 1'b1);
    check("rd3_resp", rd_resp[1], 2'b00);

    // ch1 kicked every 8 cycles never times out
    wr1(12'h018, 32'd10, 2'b00);
    wr1(12'h010, 32'd1, 2'b00);
    st = cyc;
    while (cyc < st + 100) begin
      wr1(12'h014, 32'd1, 2'b00);
      while (cyc < last_commit + 6) begin @(posedge clk); #1; end
    end
    check("wto1_kicked", WTO[1], 1'b0);
    wr1(12'h014, 32'd1, 2'b00);
    e = last_commit;
    while (cyc < e + 9) begin @(posedge clk); #1; end
    wr1(12'h014, 32'd1, 2'b00);
    check("kick_on_compare_edge", last_commit - e, 11);
    check("wto1_kick_wins", WTO[1], 1'b0);
    rd_chk("count1_after_kick", 12'h01C, 32'd1);
    check("wto1_still_clear", WTO[1], 1'b0);
    wr1(12'h010, 32'd0, 2'b00);

    // 4-beat INCR write, then unmapped write
    axi_write(12'h000, 4, {32'hDEAD, 32'h20, 32'h1, 32'h1}, 4'hF, r);
    check("burst_bresp", r, 2'b00);
    rd_chk("burst_tocnt0", 12'h008, 32'h20);
    rd_chk("burst_en0", 12'h000, 32'h1);
    wr1(12'h200, 32'hFFFF_FFFF, 2'b10);
    rd_chk("unmapped_nochange", 12'h008, 32'h20);
    axi_read(12'h200, 1, 0);
    check("unmapped_rresp", rd_resp[0], 2'b10);
    check("unmapped_rdata", rd_data[0], 32'h0);
    axi_write(12'h008, 1, {96'h0, 32'h0000_1100}, 4'b0010, r);
    rd_chk("tocnt_strb", 12'h008, 32'h1120);
    axi_write(12'h000, 1, {96'h0, 32'h0}, 4'b1110, r);
    rd_chk("en_strb_ignored", 12'h000, 32'h1);

    // simultaneous AW and AR: write first
    AWVALID = 1'b1; AWADDR = 32'h028; AWLEN = 8'd0; AWID = 8'h11;
    ARVALID = 1'b1; ARADDR = 32'h028; ARLEN = 8'd0; ARID = 8'h22;
    #1;
    check("both_awready", AWREADY, 1'b1);
    check("both_arready", ARREADY, 1'b0);
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'd3; WSTRB = 4'hF; WLAST = 1'b1;
    #1;
    check("both_wready", WREADY, 1'b1);
    check("both_arready_w", ARREADY, 1'b0);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    check("both_bvalid", BVALID, 1'b1);
    check("both_bid", BID, 8'h11);
    @(posedge clk); #1;
    BREADY = 1'b0;
    #1;
    check("both_arready_after", ARREADY, 1'b1);
    @(posedge clk); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    check("both_rvalid", RVALID, 1'b1);
    check("both_rdata", RDATA, 32'd3);
    check("both_rid", RID, 8'h22);
    @(posedge clk); #1;
    RREADY = 1'b0;

    // ch2 timeout, disable keeps flag, W1C clears only bit 2
    wr1(12'h020, 32'd1, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    check("wto_ch2_set", WTO, 4'b0101);
    wr1(12'h020, 32'd0, 2'b00);
    check("wto2_after_disable", WTO[2], 1'b1);
    wr1(12'h100, 32'h4, 2'b00);
    check("wto_after_w1c", WTO, 4'b0001);
    rd_chk("status_read", 12'h100, 32'h1);

    // reset in the middle of a read burst
    ARVALID = 1'b1; ARADDR = 32'h000; ARLEN = 8'd3; ARID = 8'h33;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("mid_rvalid", RVALID, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_rvalid", RVALID, 1'b0);
    check("rst_mid_rdata", RDATA, 32'h0);
    check("rst_mid_wto", WTO, 4'h0);
    check("rst_mid_irq", IRQ, 1'b0);
    check("rst_mid_awready", AWREADY, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("rst_en0", 12'h000, 32'h0);
    rd_chk("rst_tocnt0", 12'h008, 32'h0);
    rd_chk("rst_tocnt2", 12'h028, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wdt_multi_wrapper.md
WDT_MULTI_WRAPPER -- requirements
Module: wdt_multi_wrapper

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent watchdog channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter/timeout width (8..32).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  sole clock
- rst  in  1  async active-high reset
- AW channel: AWID `AXI_IDS_BITS`, AWADDR `AXI_ADDR_BITS`, AWLEN `AXI_LEN_BITS`, AWSIZE `AXI_SIZE_BITS`, AWBURST 2, AWVALID 1 (in); AWREADY 1 (out)
- W channel: WDATA `AXI_DATA_BITS`, WSTRB `AXI_STRB_BITS`, WLAST 1, WVALID 1 (in); WREADY 1 (out)
- B channel: BID `AXI_IDS_BITS`, BRESP 2, BVALID 1 (out); BREADY 1 (in)
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (in, AXI widths); ARREADY 1 (out)
- R channel: RID, RDATA, RRESP, RLAST, RVALID (out); RREADY 1 (in)
- WTO  out  NUM_CH  per-channel sticky timeout flag
- IRQ  out  1  OR of WTO

Function
REQ-010 Register map (ADDR[11:0]); channel c at base 0x10*c: +0x0 EN (bit0, RW), +0x4 KICK (write bit0=1 clears counter, reads 0), +0x8 TOCNT (CNT_W bits, RW), +0xC COUNT (RO).
REQ-011 0x100 STATUS: bits [NUM_CH-1:0] = WTO, RW1C; other offsets and channels >= NUM_CH are unmapped.
REQ-012 Writes honour WSTRB per byte for TOCNT; EN, KICK, STATUS require WSTRB[0]=1, else ignored.
REQ-013 FSM states IDLE, WRITE, WRESP, READ; reset state IDLE.
REQ-014 IDLE: AWREADY=1; ARREADY = !AWVALID; AW handshake wins over simultaneous AR.
- AW handshake -> capture AWID, AWADDR, AWLEN -> WRITE.
- AR handshake -> capture ARID, ARADDR, ARLEN, beat count 0 -> READ.
REQ-015 WRITE: WREADY=1; each W handshake commits one beat then address += 4 (INCR regardless of AWBURST); beat with WLAST=1 -> WRESP.
REQ-016 WRESP: BVALID=1, BID = captured AWID; BRESP = 2'b10 if any beat hit an unmapped offset, else 2'b00; BVALID&BREADY -> IDLE.
REQ-017 READ: RVALID=1, RID = captured ARID, RDATA = register at current address (zero-extended; 0 if unmapped), RRESP 2'b10 unmapped else 2'b00, RLAST = (beat == captured ARLEN).
REQ-018 READ: RVALID&RREADY advances address += 4 and beat count; with RLAST -> IDLE; RDATA/RID/RLAST stable while RVALID&!RREADY.
REQ-019 Counter, per channel, each clk edge: EN=0 -> COUNT=0; EN=1 & WTO=0 & COUNT==TOCNT -> WTO set, COUNT held; EN=1 & WTO=0 -> COUNT+1; EN=1 & WTO=1 -> COUNT held.
REQ-020 Timing: with TOCNT=N, the EN=1 write commits at edge 0 and WTO rises at edge N+1; TOCNT=0 -> WTO at edge 1.
REQ-021 KICK commit forces COUNT=0 that edge and suppresses a WTO set on the same edge (kick wins).
REQ-022 EN written 0 clears COUNT but leaves WTO; only STATUS W1C clears WTO.
REQ-023 W1C on same edge as a new timeout for that channel: set wins, WTO stays 1.
REQ-024 TOCNT rewritten while counting takes effect at the next compare; COUNT > new TOCNT never times out until a kick or disable (no wrap; COUNT saturates at all-ones).
REQ-025 IRQ = |WTO, combinational.

Reset
REQ-030 rst high SHALL immediately force: state IDLE, all EN/TOCNT/COUNT/WTO = 0, BVALID=0, RVALID=0, WREADY=0, RLAST=0, BID/RID/RDATA/BRESP/RRESP = 0, IRQ=0.
REQ-031 Reset mid-burst aborts the transaction with no B or R response; AWREADY=1 and ARREADY=!AWVALID while in IDLE after reset.

Verification
REQ-040 Write TOCNT ch0 = 5, EN ch0 = 1 -> WTO[0] rises exactly 6 cycles after the EN write beat; IRQ=1; COUNT ch0 reads 5.
REQ-041 TOCNT ch1 = 10, EN=1, KICK every 8 cycles for 100 cycles -> WTO[1] stays 0; KICK on the compare edge -> no timeout.
REQ-042 4-beat INCR write from 0x000 (EN=1, KICK, TOCNT=0x20, COUNT) -> BRESP=2'b00; then AWADDR 0x200 single beat -> BRESP=2'b10, no state change.
REQ-043 3-beat read from 0x008 with RREADY toggling -> RDATA = TOCNT0, COUNT0, EN1, RLAST only on beat 3, data held during stalls.
REQ-044 AWVALID and ARVALID raised same cycle in IDLE -> write served first, read accepted after BVALID&BREADY.
REQ-045 Timeout on ch2, write STATUS 0x4 -> WTO[2]=0; assert rst during a read burst -> RVALID=0 immediately, all registers 0.
